// File: rtl/config_bus_arbiter.sv
// Round-robin arbiter sharing one config-message bus among NUM_REQ requesters.
// Define CFG_ARB_RETRY_EN to re-issue failed transactions up to MAX_RETRY times.
module config_bus_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int ADDR_SIZE    = 4,
   parameter int PAYLOAD_SIZE = 8,
   parameter int RESP_LAT     = 1,
   parameter int MAX_RETRY    = 2
) (
   input  logic                                          clk,
   input  logic                                          reset,
   input  logic [NUM_REQ-1:0]                            req_val,
   output logic [NUM_REQ-1:0]                            req_rdy,
   input  logic [NUM_REQ*(ADDR_SIZE+PAYLOAD_SIZE+1)-1:0] req_msg,
   output logic [NUM_REQ-1:0]                            resp_val,
   input  logic [NUM_REQ-1:0]                            resp_rdy,
   output logic [ADDR_SIZE+PAYLOAD_SIZE:0]               resp_msg,
   output logic                                          resp_ok,
   output logic [ADDR_SIZE+PAYLOAD_SIZE:0]               cfg_msg,
   input  logic [ADDR_SIZE+PAYLOAD_SIZE:0]               cfg_resp,
   output logic                                          busy
);

   localparam int MSG_W = ADDR_SIZE + PAYLOAD_SIZE + 1;
   localparam int PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW    = $clog2(RESP_LAT + 1);

   if (NUM_REQ < 2 || RESP_LAT < 1 || MAX_RETRY < 0) begin : g_param_chk
      $error("config_bus_arbiter: illegal parameter value");
   end

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_e;

   state_e            state_q, state_d;
   logic [PW-1:0]     rr_q, rr_d;
   logic [PW-1:0]     gnt_q, gnt_d;
   logic [MSG_W-1:0]  msg_q, msg_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [MSG_W-1:0]  rmsg_q, rmsg_d;
   logic              rok_q, rok_d;

`ifdef CFG_ARB_RETRY_EN
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   logic [RW-1:0]     retry_q, retry_d;
`endif

   logic [PW-1:0]     sel;
   logic [PW-1:0]     j;
   logic              sel_vld;
   int                idx;
   logic              ok_now;

   // Scan from rr_q downwards in priority so the nearest requester wins last.
   always_comb begin
      sel     = '0;
      sel_vld = 1'b0;
      idx     = 0;
      j       = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(rr_q) + k) % NUM_REQ;
         j   = idx[PW-1:0];
         if (req_val[j]) begin
            sel_vld = 1'b1;
            sel     = j;
         end
      end
   end

   // Read-type requests never report success, whatever the bus echoes.
   assign ok_now = msg_q[PAYLOAD_SIZE] & cfg_resp[PAYLOAD_SIZE] &
                   (cfg_resp[MSG_W-1 -: ADDR_SIZE] ==
                    msg_q[MSG_W-1 -: ADDR_SIZE]);

   always_comb begin
      state_d  = state_q;
      rr_d     = rr_q;
      gnt_d    = gnt_q;
      msg_d    = msg_q;
      cnt_d    = cnt_q;
      rmsg_d   = rmsg_q;
      rok_d    = rok_q;
`ifdef CFG_ARB_RETRY_EN
      retry_d  = retry_q;
`endif
      req_rdy  = '0;
      resp_val = '0;
      cfg_msg  = '0;
      unique case (state_q)
         IDLE: begin
            if (sel_vld) begin
               req_rdy[sel] = 1'b1;
               gnt_d        = sel;
               msg_d        = req_msg[sel*MSG_W +: MSG_W];
               rr_d         = (sel == PW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
               state_d      = ISSUE;
`ifdef CFG_ARB_RETRY_EN
               retry_d      = '0;
`endif
            end
         end
         ISSUE: begin
            cfg_msg = msg_q;
            cnt_d   = CW'(RESP_LAT - 1);
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == '0) begin
               rmsg_d  = msg_q[PAYLOAD_SIZE] ? cfg_resp : '0;
               rok_d   = ok_now;
               state_d = RESP;
`ifdef CFG_ARB_RETRY_EN
               if (!ok_now && (retry_q < RW'(MAX_RETRY))) begin
                  retry_d = retry_q + 1'b1;
                  state_d = ISSUE;
               end
`endif
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            resp_val[gnt_q] = 1'b1;
            if (resp_rdy[gnt_q]) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         rr_q    <= '0;
         gnt_q   <= '0;
         msg_q   <= '0;
         cnt_q   <= '0;
         rmsg_q  <= '0;
         rok_q   <= 1'b0;
`ifdef CFG_ARB_RETRY_EN
         retry_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         gnt_q   <= gnt_d;
         msg_q   <= msg_d;
         cnt_q   <= cnt_d;
         rmsg_q  <= rmsg_d;
         rok_q   <= rok_d;
`ifdef CFG_ARB_RETRY_EN
         retry_q <= retry_d;
`endif
      end
   end

   assign resp_msg = rmsg_q;
   assign resp_ok  = rok_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_config_bus_arbiter.sv
// Self-checking bench for config_bus_arbiter with a stub config register at addr 3.
// Honours CFG_ARB_RETRY_EN to match the build under test.
module tb_config_bus_arbiter;

   localparam int N   = 4;
   localparam int AW  = 4;
   localparam int PW  = 8;
   localparam int MW  = AW + PW + 1;
   localparam int LAT = 1;
   localparam int MR  = 2;
`ifdef CFG_ARB_RETRY_EN
   localparam bit RETRY = 1'b1;
`else
   localparam bit RETRY = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [N-1:0]  req_val, req_rdy, resp_val, resp_rdy;
   logic [MW-1:0] msgs [N];
   logic [N*MW-1:0] req_msg;
   logic [MW-1:0] resp_msg, cfg_msg, cfg_resp;
   logic          resp_ok, busy;

   int checks = 0;
   int errors = 0;
   int rr = 0;

   always #5 clk = ~clk;

   assign req_msg = {msgs[3], msgs[2], msgs[1], msgs[0]};

   // Stub register: only a write to addr 3 is echoed as a success.
   always_ff @(posedge clk) begin
      if (reset) cfg_resp <= '0;
      else if (cfg_msg[PW] && cfg_msg[MW-1 -: AW] == 4'h3)
         cfg_resp <= {4'h3, 1'b1, cfg_msg[PW-1:0]};
      else cfg_resp <= '0;
   end

   config_bus_arbiter #(
      .NUM_REQ(N), .ADDR_SIZE(AW), .PAYLOAD_SIZE(PW),
      .RESP_LAT(LAT), .MAX_RETRY(MR)
   ) dut (
      .clk(clk), .reset(reset),
      .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg),
      .resp_val(resp_val), .resp_rdy(resp_rdy),
      .resp_msg(resp_msg), .resp_ok(resp_ok),
      .cfg_msg(cfg_msg), .cfg_resp(cfg_resp), .busy(busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [N-1:0] v, input int p);
      int q;
      for (int k = 0; k < N; k++) begin
         q = (p + k) % N;
         if (v[q[1:0]]) return q;
      end
      return -1;
   endfunction

   task automatic run_txn(input logic [N-1:0] vmask, input int stall,
                          output int g, output int cyc_resp);
      logic [MW-1:0] m, em, held;
      logic eok;
      int issues, exp_issues, c;
      bit seen;
      req_val  = vmask;
      resp_rdy = (stall > 0) ? '0 : '1;
      #1;
      g  = pick(vmask, rr);
      m  = msgs[g[1:0]];
      eok = m[PW] && (m[MW-1 -: AW] == 4'h3);
      em  = eok ? m : '0;
      exp_issues = (!eok && RETRY) ? MR + 1 : 1;
      rr = (g + 1) % N;
      check("req_rdy_grant", 32'(req_rdy), 1 << g);
      tick();
      issues = 0;
      seen = 1'b0;
      cyc_resp = -1;
      c = 1;
      while (!seen && c <= 40) begin
         if (resp_val != '0) begin
            seen = 1'b1;
            cyc_resp = c;
         end else begin
            if (cfg_msg != '0) begin
               issues++;
               check("cfg_msg", 32'(cfg_msg), 32'(m));
            end
            tick();
            c++;
         end
      end
      check("resp_val", 32'(resp_val), 1 << g);
      check("resp_msg", 32'(resp_msg), 32'(em));
      check("resp_ok", 32'(resp_ok), 32'(eok));
      check("issue_count", issues, exp_issues);
      check("req_rdy_in_resp", 32'(req_rdy), 0);
      check("busy_in_resp", 32'(busy), 1);
      held = resp_msg;
      for (int s = 0; s < stall; s++) begin
         tick();
         check("stall_resp_val", 32'(resp_val), 1 << g);
         check("stall_resp_msg", 32'(resp_msg), 32'(held));
         check("stall_req_rdy", 32'(req_rdy), 0);
         check("stall_busy", 32'(busy), 1);
      end
      if (stall > 0) resp_rdy = '1;
      tick();
      check("resp_val_clear", 32'(resp_val), 0);
      check("busy_idle", 32'(busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int g, cyc;
      int order [5];
      req_val  = '0;
      resp_rdy = '1;
      for (int i = 0; i < N; i++) msgs[i] = '0;
      reset = 1'b1;
      repeat (3) tick();
      check("rst_req_rdy", 32'(req_rdy), 0);
      check("rst_resp_val", 32'(resp_val), 0);
      check("rst_resp_msg", 32'(resp_msg), 0);
      check("rst_resp_ok", 32'(resp_ok), 0);
      check("rst_cfg_msg", 32'(cfg_msg), 0);
      check("rst_busy", 32'(busy), 0);
      reset = 1'b0;

      msgs[0] = {4'h3, 1'b1, 8'hA5};
      run_txn(4'b0001, 0, g, cyc);
      check("t1_resp_cycle", cyc, 2 + LAT);
      check("t1_resp_msg", 32'(resp_msg), 32'h7A5);

      msgs[1] = {4'h7, 1'b1, 8'h11};
      run_txn(4'b0010, 0, g, cyc);

      msgs[0] = {4'h3, 1'b0, 8'h42};
      run_txn(4'b0001, 0, g, cyc);

      msgs[0] = {4'h3, 1'b1, 8'h01};
      msgs[1] = {4'h3, 1'b1, 8'h02};
      msgs[2] = {4'h3, 1'b1, 8'h03};
      msgs[3] = {4'h3, 1'b1, 8'h04};
      run_txn(4'b1111, 5, g, cyc);

      msgs[2] = {4'h3, 1'b1, 8'h5C};
      req_val = 4'b0100;
      #1;
      check("t5_grant", 32'(req_rdy), 32'h4);
      tick();
      req_val = '0;
      tick();
      check("t5_busy_wait", 32'(busy), 1);
      reset = 1'b1;
      tick();
      check("t5_req_rdy", 32'(req_rdy), 0);
      check("t5_resp_val", 32'(resp_val), 0);
      check("t5_resp_msg", 32'(resp_msg), 0);
      check("t5_resp_ok", 32'(resp_ok), 0);
      check("t5_cfg_msg", 32'(cfg_msg), 0);
      check("t5_busy", 32'(busy), 0);
      rr = 0;
      reset = 1'b0;

      for (int t = 0; t < 5; t++) begin
         run_txn(4'b1111, 0, g, cyc);
         order[t] = g;
      end
      check("t3_order0", order[0], 0);
      check("t3_order1", order[1], 1);
      check("t3_order2", order[2], 2);
      check("t3_order3", order[3], 3);
      check("t3_order4", order[4], 0);

      for (int t = 0; t < 25; t++) begin
         for (int i = 0; i < N; i++) begin
            msgs[i] = {($urandom_range(0, 1) == 1) ? 4'h3
                                                   : 4'($urandom_range(0, 15)),
                       1'($urandom_range(0, 3) != 0),
                       8'($urandom) | 8'h01};
         end
         run_txn(4'($urandom_range(1, 15)), (t % 7 == 3) ? 2 : 0, g, cyc);
      end

      req_val = '0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
